aes_round_ctrl: RTL and testbench

Round sequencer for the iterative AES engine datapath.
- Runs key expansion once per key load.
- Steps each 128-bit block through the initial AddRoundKey, Nr-1 full rounds and the final round.
- Generates all datapath enables, the round index and the final-round flag.
- Sits inside the engine, between the streamer-facing valid/ready handshake and the round/key-schedule datapath. It is driven by the top FSM's enable/clear.

---
 rtl/aes_round_ctrl_pkg.sv | 12 +
 rtl/aes_round_ctrl.sv | 78 +++++++
 tb/tb_aes_round_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// aes_round_ctrl_pkg: state/key-length types and round-count helpers for the AES round sequencer
package aes_round_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_KEY_OK, S_ROUND, S_DONE} aes_round_state_t;
  typedef enum logic [1:0] {KEY_128 = 2'b00, KEY_192 = 2'b01, KEY_256 = 2'b10, KEY_RSVD = 2'b11} aes_key_len_t;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  // The reserved encoding falls back to AES-128.
  function automatic logic [3:0] key_len_to_nr(input aes_key_len_t len);
    return len == KEY_192 ? NR_192 : len == KEY_256 ? NR_256 : NR_128;
  endfunction
endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences key expansion and per-block AES rounds, driving datapath enables
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR_MAX = 14,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           enable_i,
  input  logic [1:0]                     key_len_i,
  input  logic                           key_valid_i,
  output logic                           key_ready_o,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [$clog2(NR_MAX+1)-1:0]    round_o,
  output logic                           keyexp_en_o,
  output logic                           load_state_o,
  output logic                           state_en_o,
  output logic                           final_round_o,
  output logic                           busy_o,
  output logic [CNT_W-1:0]               block_cnt_o
);
  localparam int RW = $clog2(NR_MAX + 1);
  aes_round_state_t state, state_nxt;
  logic [RW-1:0] nr, round_nxt;
  logic key_hs, blk_hs, done_hs, last;
  assign key_hs  = key_valid_i & key_ready_o;
  assign blk_hs  = in_valid_i & in_ready_o;
  assign done_hs = enable_i & (state == S_DONE) & out_ready_i;
  assign last    = round_o == nr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= S_IDLE;
      round_o     <= '0;
      nr          <= RW'(NR_128);
      block_cnt_o <= '0;
    end else if (clear) begin
      state       <= S_IDLE;
      round_o     <= '0;
      nr          <= RW'(NR_128);
      block_cnt_o <= '0;
    end else begin
      state   <= state_nxt;
      round_o <= round_nxt;
      if (key_hs) nr <= RW'(key_len_to_nr(aes_key_len_t'(key_len_i)));
      if (done_hs) block_cnt_o <= block_cnt_o + 1'b1;
    end
  always_comb begin
    state_nxt = state;
    round_nxt = round_o;
    if (enable_i) begin
      case (state)
        S_IDLE:   state_nxt = key_hs ? S_KEYEXP : S_IDLE;
        S_KEYEXP: state_nxt = last ? S_KEY_OK : S_KEYEXP;
        S_KEY_OK: state_nxt = key_hs ? S_KEYEXP : blk_hs ? S_ROUND : S_KEY_OK;
        S_ROUND:  state_nxt = last ? S_DONE : S_ROUND;
        S_DONE:   state_nxt = !out_ready_i ? S_DONE : blk_hs ? S_ROUND : S_KEY_OK;
        default:  state_nxt = S_IDLE;
      endcase
      round_nxt = (key_hs | blk_hs) ? RW'(1) : (busy_o & !last) ? round_o + 1'b1 : '0;
    end
  end
  // Strobes are gated by enable; out_valid, busy and final_round reflect frozen state.
  always_comb begin
    key_ready_o   = enable_i & ((state == S_IDLE) | (state == S_KEY_OK));
    in_ready_o    = enable_i & (state == S_KEY_OK ? !key_valid_i : state == S_DONE ? out_ready_i : 1'b0);
    load_state_o  = in_valid_i & in_ready_o;
    state_en_o    = load_state_o | (enable_i & (state == S_ROUND));
    keyexp_en_o   = enable_i & (state == S_KEYEXP);
    busy_o        = (state == S_KEYEXP) | (state == S_ROUND);
    final_round_o = (state == S_ROUND) & last;
    out_valid_o   = state == S_DONE;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed and randomized checks of the AES round sequencer against timing rules
module tb_aes_round_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, enable_i = 1'b0;
  logic [1:0] key_len_i = 2'b00;
  logic key_valid_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic key_ready_o, in_ready_o, out_valid_o, keyexp_en_o, load_state_o, state_en_o, final_round_o, busy_o;
  logic [3:0] round_o;
  logic [15:0] block_cnt_o;
  int chk = 0, err = 0, model_cnt = 0;

  aes_round_ctrl #(.NR_MAX(14), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable_i(enable_i),
    .key_len_i(key_len_i), .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .round_o(round_o), .keyexp_en_o(keyexp_en_o),
    .load_state_o(load_state_o), .state_en_o(state_en_o), .final_round_o(final_round_o),
    .busy_o(busy_o), .block_cnt_o(block_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // AES: Nr = 10 + 2*(key bits above 128)/64; reserved code behaves as 128.
  function automatic int nr_of(input int len);
    return (len < 3) ? 10 + 2 * len : 10;
  endfunction

  task automatic load_key(input int len, input logic with_block);
    int n;
    n = nr_of(len);
    key_len_i = 2'(len);
    key_valid_i = 1'b1;
    in_valid_i = with_block;
    #1;
    check("key_ready_hs", 32'(key_ready_o), 1);
    check("in_ready_key_prio", 32'(in_ready_o), 0);
    check("load_key_prio", 32'(load_state_o), 0);
    step;
    key_valid_i = 1'b0;
    in_valid_i = 1'b0;
    for (int i = 1; i <= n; i++) begin
      #1;
      check("keyexp_en", 32'(keyexp_en_o), 1);
      check("keyexp_round", 32'(round_o), 32'(i));
      check("keyexp_key_ready", 32'(key_ready_o), 0);
      step;
    end
    #1;
    check("keyexp_done", 32'(keyexp_en_o), 0);
    check("keyok_key_ready", 32'(key_ready_o), 1);
    check("keyok_in_ready", 32'(in_ready_o), 1);
    check("keyok_round", 32'(round_o), 0);
    check("keyok_busy", 32'(busy_o), 0);
  endtask

  task automatic start_block;
    in_valid_i = 1'b1;
    #1;
    check("accept_load", 32'(load_state_o), 1);
    check("accept_state_en", 32'(state_en_o), 1);
    check("accept_round0", 32'(round_o), 0);
    step;
    in_valid_i = 1'b0;
  endtask

  task automatic rounds(input int from, input int upto, input int n);
    for (int r = from; r <= upto; r++) begin
      #1;
      check("round_idx", 32'(round_o), 32'(r));
      check("round_state_en", 32'(state_en_o), 1);
      check("round_final", 32'(final_round_o), 32'(r == n));
      check("round_no_out", 32'(out_valid_o), 0);
      check("round_busy", 32'(busy_o), 1);
      step;
    end
  endtask

  task automatic finish_block(input int stall);
    for (int s = 0; s < stall; s++) begin
      out_ready_i = 1'b0;
      in_valid_i = 1'b1;
      #1;
      check("stall_out_valid", 32'(out_valid_o), 1);
      check("stall_round0", 32'(round_o), 0);
      check("stall_no_accept", 32'(load_state_o), 0);
      check("stall_key_ready", 32'(key_ready_o), 0);
      check("stall_cnt", 32'(block_cnt_o), 32'(model_cnt & 16'hffff));
      step;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    #1;
    check("done_out_valid", 32'(out_valid_o), 1);
    check("done_in_ready", 32'(in_ready_o), 1);
    step;
    out_ready_i = 1'b0;
    model_cnt++;
    #1;
    check("post_done_cnt", 32'(block_cnt_o), 32'(model_cnt & 16'hffff));
    check("post_done_out_valid", 32'(out_valid_o), 0);
    check("post_done_key_ready", 32'(key_ready_o), 1);
  endtask

  initial begin
    int len, n;
    #2;
    check("rst_key_ready", 32'(key_ready_o), 0);
    check("rst_out_valid", 32'(out_valid_o), 0);
    check("rst_round", 32'(round_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_cnt", 32'(block_cnt_o), 0);
    check("rst_keyexp", 32'(keyexp_en_o), 0);
    step;
    reset_n = 1'b1;
    enable_i = 1'b1;
    #1;
    check("idle_key_ready", 32'(key_ready_o), 1);
    check("idle_in_ready", 32'(in_ready_o), 0);
    step;

    load_key(0, 1'b0);

    load_key(2, 1'b0);
    start_block;
    rounds(1, 14, 14);
    finish_block(0);

    load_key(0, 1'b0);
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check("b2b_first_load", 32'(load_state_o), 1);
    step;
    for (int b = 0; b < 3; b++) begin
      for (int r = 1; r <= 10; r++) begin
        #1;
        check("b2b_round", 32'(round_o), 32'(r));
        step;
      end
      if (b == 2) in_valid_i = 1'b0;
      #1;
      check("b2b_out_valid", 32'(out_valid_o), 1);
      check("b2b_reload", 32'(load_state_o), 32'(b < 2));
      step;
      model_cnt++;
    end
    out_ready_i = 1'b0;
    #1;
    check("b2b_cnt", 32'(block_cnt_o), 32'(model_cnt));
    check("b2b_out_idle", 32'(out_valid_o), 0);

    start_block;
    rounds(1, 10, 10);
    finish_block(5);

    load_key(1, 1'b1);

    start_block;
    rounds(1, 4, 12);
    enable_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("hold_round", 32'(round_o), 5);
      check("hold_state_en", 32'(state_en_o), 0);
      check("hold_out_valid", 32'(out_valid_o), 0);
      step;
    end
    enable_i = 1'b1;
    rounds(5, 12, 12);
    enable_i = 1'b0;
    out_ready_i = 1'b1;
    #1;
    check("dis_done_out_valid", 32'(out_valid_o), 1);
    check("dis_done_in_ready", 32'(in_ready_o), 0);
    step;
    #1;
    check("dis_done_cnt", 32'(block_cnt_o), 32'(model_cnt));
    check("dis_done_hold", 32'(out_valid_o), 1);
    out_ready_i = 1'b0;
    enable_i = 1'b1;
    finish_block(0);

    start_block;
    rounds(1, 4, 12);
    clear = 1'b1;
    #1;
    check("pre_clear_round", 32'(round_o), 5);
    step;
    clear = 1'b0;
    model_cnt = 0;
    #1;
    check("clear_key_ready", 32'(key_ready_o), 1);
    check("clear_in_ready", 32'(in_ready_o), 0);
    check("clear_round", 32'(round_o), 0);
    check("clear_cnt", 32'(block_cnt_o), 0);
    check("clear_busy", 32'(busy_o), 0);
    check("clear_out_valid", 32'(out_valid_o), 0);
    step;

    key_len_i = 2'b10;
    key_valid_i = 1'b1;
    step;
    key_valid_i = 1'b0;
    step;
    step;
    reset_n = 1'b0;
    #1;
    check("arst_round", 32'(round_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_keyexp", 32'(keyexp_en_o), 0);
    step;
    reset_n = 1'b1;
    #1;
    check("arst_idle_ready", 32'(key_ready_o), 1);
    step;

    for (int it = 0; it < 6; it++) begin
      len = int'($urandom_range(0, 3));
      n = nr_of(len);
      load_key(len, 1'(it & 1));
      for (int b = 0; b < int'($urandom_range(1, 2)); b++) begin
        start_block;
        rounds(1, n, n);
        finish_block(int'($urandom_range(0, 4)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
